gmux_sel_ctrl: RTL and testbench

- Sequencer that drives the select input IS0 of the downstream GMUX clock multiplexer.
- Synchronises an asynchronous select request into the control clock domain.
- Before IS0 changes, requests a clock-gate-off from the consumer logic and waits for an acknowledge or a timeout.
- After the change, holds the gate off for a settle window, then releases it, so GMUX output switching never reaches running logic.

---
 rtl/gmux_sel_ctrl.sv | 103 ++++++++++
 tb/tb_gmux_sel_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/gmux_sel_ctrl.sv
// Select sequencer for the GMUX IS0 input: synchronises REQ_SEL, gates the
// consumer clock around the IS0 change, then releases it after a settle window.
module gmux_sel_ctrl #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned ACK_TIMEOUT   = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic        RESET_SEL     = 1'b0
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic REQ_SEL,
  input  logic GATE_ACK,
  output logic IS0,
  output logic GATE_OFF,
  output logic BUSY,
  output logic DONE,
  output logic ERR
);

  localparam int unsigned CNT_MAX = (ACK_TIMEOUT > SETTLE_CYCLES) ? ACK_TIMEOUT : SETTLE_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] ACK_LAST    = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SETTLE
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   target;
  logic [SYNC_STAGES-1:0] sync;
  logic                   req_s;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync <= {SYNC_STAGES{RESET_SEL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], REQ_SEL};
    end
  end

  assign req_s = sync[SYNC_STAGES-1];

  // IS0 only moves on the DRAIN exit edge, while GATE_OFF is still high.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      cnt      <= '0;
      target   <= RESET_SEL;
      IS0      <= RESET_SEL;
      GATE_OFF <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_s != IS0) begin
            target   <= req_s;
            state    <= DRAIN;
            GATE_OFF <= 1'b1;
            BUSY     <= 1'b1;
            cnt      <= '0;
          end
        end
        DRAIN: begin
          if (GATE_ACK) begin
            IS0   <= target;
            state <= SETTLE;
            cnt   <= '0;
          end else if (cnt == ACK_LAST) begin
            IS0   <= target;
            state <= SETTLE;
            cnt   <= '0;
            ERR   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state    <= IDLE;
            GATE_OFF <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmux_sel_ctrl.sv
// Directed bench for gmux_sel_ctrl with default parameters; edge numbers count
// rising edges after the stimulus change, outputs sampled 1 time unit after each edge.
module tb_gmux_sel_ctrl;

  logic CLK;
  logic RSTN;
  logic REQ_SEL;
  logic GATE_ACK;
  logic IS0;
  logic GATE_OFF;
  logic BUSY;
  logic DONE;
  logic ERR;

  int unsigned n_cmp;
  int unsigned n_err;

  gmux_sel_ctrl #(
    .SYNC_STAGES  (2),
    .ACK_TIMEOUT  (16),
    .SETTLE_CYCLES(4),
    .RESET_SEL    (1'b0)
  ) dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .REQ_SEL (REQ_SEL),
    .GATE_ACK(GATE_ACK),
    .IS0     (IS0),
    .GATE_OFF(GATE_OFF),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ERR     (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input int e, input logic is0, input logic goff,
                      input logic busy, input logic done, input logic err);
    chk($sformatf("%s e%0d IS0", tag, e), IS0, is0);
    chk($sformatf("%s e%0d GATE_OFF", tag, e), GATE_OFF, goff);
    chk($sformatf("%s e%0d BUSY", tag, e), BUSY, busy);
    chk($sformatf("%s e%0d DONE", tag, e), DONE, done);
    chk($sformatf("%s e%0d ERR", tag, e), ERR, err);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    RSTN     = 1'b0;
    REQ_SEL  = 1'b0;
    GATE_ACK = 1'b1;

    // Reset and idle with matching request.
    tick(3);
    chk5("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    RSTN = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      chk5("idle", e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Normal switch 0->1 with GATE_ACK held high.
    REQ_SEL = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick(1);
      chk5("norm01", e, e >= 4, e >= 3 && e <= 7, e >= 3 && e <= 7, e == 8, 1'b0);
    end

    // Timeout switch 1->0 with GATE_ACK held low.
    GATE_ACK = 1'b0;
    REQ_SEL  = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      tick(1);
      chk5("tmo10", e, e < 19, e >= 3 && e <= 22, e >= 3 && e <= 22, e == 23, e == 19);
    end

    // GATE_ACK rises in the last DRAIN cycle: switch on that edge, no ERR.
    REQ_SEL = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      tick(1);
      chk5("coinc01", e, e >= 19, e >= 3 && e <= 22, e >= 3 && e <= 22, e == 23, 1'b0);
      if (e == 18) GATE_ACK = 1'b1;
    end

    // Normal switch 1->0.
    REQ_SEL = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick(1);
      chk5("norm10", e, e < 4, e >= 3 && e <= 7, e >= 3 && e <= 7, e == 8, 1'b0);
    end

    // Request bounce 0->1->0 during DRAIN: two back-to-back sequences.
    GATE_ACK = 1'b0;
    REQ_SEL  = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick(1);
      chk5("bounce", e, e >= 7 && e <= 12,
           (e >= 3 && e <= 10) || (e >= 12 && e <= 16),
           (e >= 3 && e <= 10) || (e >= 12 && e <= 16),
           e == 11 || e == 17, 1'b0);
      if (e == 4) REQ_SEL = 1'b0;
      if (e == 6) GATE_ACK = 1'b1;
    end

    // Reset asserted mid-SETTLE, away from any clock edge.
    REQ_SEL = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      chk5("pre_rst", e, e >= 4, e >= 3, e >= 3, 1'b0, 1'b0);
    end
    #2;
    RSTN = 1'b0;
    #1;
    chk5("async_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    chk5("in_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    RSTN = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick(1);
      chk5("post_rst", e, e >= 4, e >= 3 && e <= 7, e >= 3 && e <= 7, e == 8, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
